uart_recv_word_fifo: RTL and testbench

- Upstream feeder for the core's receive-request port (IRecvRequest slave side).
- Packs bytes from the UART receiver into 32-bit words and buffers them in a show-ahead FIFO.
- The core reads the head word through recv_rd, checks recv_size, and pops with recv_en.

---
 rtl/uart_recv_word_fifo.sv | 131 +++++++++++++
 tb/tb_uart_recv_word_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv_word_fifo.sv
// ============================================================================
// Module   : uart_recv_word_fifo
// Purpose  : Packs UART bytes little-endian into 32-bit words and queues them
//            in a show-ahead FIFO for the core's receive-request port.
// Options  : RECV_WORD_TIMEOUT_EN - discard a stale partial word after
//            TIMEOUT_CYCLES idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_recv_word_fifo #(
   parameter int DEPTH          = 256,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic [31:0]       recv_rd,
   output logic [ADDR_W:0]   recv_size,
   input  logic              recv_en,
   output logic              overflow,
   output logic [1:0]        partial_cnt
);

   localparam logic [ADDR_W:0]   c_depth     = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   c_count_one = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] c_ptr_one   = ADDR_W'(1);

   logic [31:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic [1:0]        r_partial;
   logic [23:0]       r_asm;
   logic              r_overflow;

   logic              w_empty;
   logic              w_full;
   logic              w_word_done;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic              w_timeout;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_depth);
   assign w_word_done = rx_valid && (r_partial == 2'd3);
   assign w_pop       = recv_en && !w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign w_push      = w_word_done && (!w_full || w_pop);
   assign w_drop      = w_word_done && w_full && !w_pop;

`ifdef RECV_WORD_TIMEOUT_EN
   localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] r_idle;

   assign w_timeout = (r_partial != 2'd0) && !rx_valid && (r_idle == c_timeout_last);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_idle <= '0;
      end else if (rx_valid || w_timeout) begin
         r_idle <= '0;
      end else if (r_partial != 2'd0) begin
         r_idle <= r_idle + 32'd1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Byte lane assembly; the fourth byte bypasses the register into the push.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_partial <= 2'd0;
         r_asm     <= '0;
      end else if (rx_valid) begin
         case (r_partial)
            2'd0: r_asm[7:0]   <= rx_data;
            2'd1: r_asm[15:8]  <= rx_data;
            2'd2: r_asm[23:16] <= rx_data;
            default: r_asm     <= '0;
         endcase
         r_partial <= r_partial + 2'd1;
      end else if (w_timeout) begin
         r_partial <= 2'd0;
         r_asm     <= '0;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {rx_data, r_asm};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_count_one;
            2'b01:   r_count <= r_count - c_count_one;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign recv_rd     = w_empty ? 32'h0 : r_mem[r_rd_ptr];
   assign recv_size   = r_count;
   assign overflow    = r_overflow;
   assign partial_cnt = r_partial;

endmodule

`default_nettype wire

// File: tb/tb_uart_recv_word_fifo.sv
// ============================================================================
// Module   : tb_uart_recv_word_fifo
// Purpose  : Scoreboard bench for uart_recv_word_fifo (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_recv_word_fifo;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              recv_en = 1'b0;
   logic [31:0]       recv_rd;
   logic [ADDR_W:0]   recv_size;
   logic              overflow;
   logic [1:0]        partial_cnt;

   uart_recv_word_fifo #(
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (10)
   ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .recv_rd     (recv_rd),
      .recv_size   (recv_size),
      .recv_en     (recv_en),
      .overflow    (overflow),
      .partial_cnt (partial_cnt)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] q_exp[$];
   int          m_pcnt = 0;
   logic [31:0] m_asm  = '0;
   logic        m_ovf  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_state(input string tag);
      logic [31:0] head;
      head = (q_exp.size() > 0) ? q_exp[0] : 32'h0;
      check({tag, ".size"}, 32'(recv_size), 32'(q_exp.size()));
      check({tag, ".head"}, recv_rd, head);
      check({tag, ".ovf"},  32'(overflow), 32'(m_ovf));
      check({tag, ".pcnt"}, 32'(partial_cnt), 32'(m_pcnt));
   endtask

   // One byte strobe, optionally with a pop in the same cycle.
   task automatic put_byte(input logic [7:0] b, input logic do_pop);
      rx_valid = 1'b1;
      rx_data  = b;
      recv_en  = do_pop;
      if (do_pop && q_exp.size() > 0) begin
         check("popdata", recv_rd, q_exp[0]);
         void'(q_exp.pop_front());
      end
      m_asm[8*m_pcnt +: 8] = b;
      if (m_pcnt == 3) begin
         if (q_exp.size() < DEPTH) q_exp.push_back(m_asm);
         else m_ovf = 1'b1;
         m_pcnt = 0;
         m_asm  = '0;
      end else begin
         m_pcnt++;
      end
      tick();
      rx_valid = 1'b0;
      recv_en  = 1'b0;
   endtask

   task automatic put_word(input logic [31:0] w, input logic pop_on_last);
      for (int i = 0; i < 4; i++) put_byte(w[8*i +: 8], (i == 3) ? pop_on_last : 1'b0);
   endtask

   task automatic pop_word();
      recv_en = 1'b1;
      if (q_exp.size() > 0) begin
         check("popdata", recv_rd, q_exp[0]);
         void'(q_exp.pop_front());
      end
      tick();
      recv_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      q_exp.delete();
      m_pcnt = 0;
      m_asm  = '0;
      m_ovf  = 1'b0;
      reset  = 1'b0;
      tick();
   endtask

   initial begin
      #22;
      check_state("reset");
      reset = 1'b0;
      tick();

      // Little-endian packing
      put_byte(8'h78, 1'b0);
      put_byte(8'h56, 1'b0);
      put_byte(8'h34, 1'b0);
      check("pcnt3", 32'(partial_cnt), 32'd3);
      put_byte(8'h12, 1'b0);
      check("pack.rd", recv_rd, 32'h12345678);
      check_state("pack");
      pop_word();
      check_state("pack_pop");

      // Pop sequence, including pop on empty
      put_word(32'h00000001, 1'b0);
      put_word(32'h00000002, 1'b0);
      pop_word();
      check_state("pop1");
      pop_word();
      check_state("pop2");
      pop_word();
      check_state("pop_empty");

      // Overflow: fifth word dropped, flag sticky
      for (int i = 1; i <= 5; i++) put_word(32'hA000_0000 + 32'(i), 1'b0);
      check_state("full");
      for (int i = 0; i < 4; i++) pop_word();
      check_state("drained");
      repeat (3) tick();
      check("ovf_sticky", 32'(overflow), 32'd1);
      do_reset();
      check_state("ovf_clr");

      // Full FIFO with simultaneous push and pop
      for (int i = 1; i <= 4; i++) put_word(32'hB000_0000 + 32'(i), 1'b0);
      put_word(32'hCAFEF00D, 1'b1);
      check_state("full_pushpop");
      for (int i = 0; i < 4; i++) pop_word();
      check_state("full_pushpop_drained");

      // Empty FIFO with simultaneous push and pop
      put_word(32'h0BADBEEF, 1'b1);
      check_state("empty_pushpop");
      pop_word();

      // Pointer wrap over 3*DEPTH words
      for (int i = 0; i < 3 * DEPTH; i++) begin
         put_word($urandom, 1'b0);
         if (i % 2 == 1) begin
            pop_word();
            pop_word();
         end
      end
      check_state("wrap");

      // Asynchronous reset mid-cycle with a partial word pending
      put_byte(8'hEE, 1'b0);
      put_byte(8'hDD, 1'b0);
      put_word(32'h11111111, 1'b0);
      #3 reset = 1'b1;
      #1;
      q_exp.delete();
      m_pcnt = 0;
      m_asm  = '0;
      m_ovf  = 1'b0;
      check_state("async_rst");
      tick();
      reset = 1'b0;
      tick();
      put_word(32'h00C0FFEE, 1'b0);
      check("after_rst.rd", recv_rd, 32'h00C0FFEE);
      check_state("after_rst");
      pop_word();

`ifdef RECV_WORD_TIMEOUT_EN
      put_byte(8'hAA, 1'b0);
      put_byte(8'hBB, 1'b0);
      repeat (10) tick();
      m_pcnt = 0;
      m_asm  = '0;
      check_state("timeout");
      put_word(32'h44332211, 1'b0);
      check("timeout.rd", recv_rd, 32'h44332211);
      check_state("timeout_word");
      pop_word();

      put_byte(8'hAA, 1'b0);
      put_byte(8'hBB, 1'b0);
      repeat (8) tick();
      put_byte(8'hCC, 1'b0);
      check("late_byte.pcnt", 32'(partial_cnt), 32'd3);
      check_state("late_byte");
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
